alu_issue_ctrl: RTL

- Instruction-side counterpart of the 8-bit ALU: accepts 16-bit instructions over a valid/ready handshake and decodes the op field into the ALU's one-hot opcode.
- Owns a small register file; drives the ALU's A/B operands from it and writes the ALU's registered result back into the destination register.
- Sits between instruction fetch and the ALU in the small CPU datapath.

---
 rtl/alu_issue_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_ctrl
//  Purpose  : Instruction issue controller for the 8-bit ALU. Accepts 16-bit
//             instruction words over a valid/ready handshake, decodes the op
//             field into the ALU one-hot opcode, drives registered operands
//             from a small register file and writes the ALU result back.
//  Options  : `define ALU_ZERO_FLAG_EN adds the zero_flag output, updated on
//             every register-file write (ALU writeback or LDI).
//  Revision : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [15:0]           instr,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [3:0]            alu_opcode,
  input  logic [DATA_W-1:0]     alu_out,
  output logic                  busy,
  output logic                  illegal,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0]     dbg_data
`ifdef ALU_ZERO_FLAG_EN
  ,
  output logic                  zero_flag
`endif
);

  localparam int c_NUM_REGS = 2 ** REG_ADDR_W;

  // FSM encoding
  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_DECODE = 2'd1;
  localparam logic [1:0] c_EXEC   = 2'd2;
  localparam logic [1:0] c_WB     = 2'd3;

  // Instruction op field values
  localparam logic [3:0] c_OP_NOP = 4'd0;
  localparam logic [3:0] c_OP_ADD = 4'd1;
  localparam logic [3:0] c_OP_OR  = 4'd2;
  localparam logic [3:0] c_OP_AND = 4'd3;
  localparam logic [3:0] c_OP_XOR = 4'd4;
  localparam logic [3:0] c_OP_LDI = 4'd5;

  // ALU one-hot opcodes; all-zero makes the ALU hold its output
  localparam logic [3:0] c_ALU_HOLD = 4'b0000;
  localparam logic [3:0] c_ALU_ADD  = 4'b0001;
  localparam logic [3:0] c_ALU_OR   = 4'b0010;
  localparam logic [3:0] c_ALU_AND  = 4'b0100;
  localparam logic [3:0] c_ALU_XOR  = 4'b1000;

  logic [1:0]            state_q, state_d;
  logic [15:0]           instr_q;
  logic [DATA_W-1:0]     regfile_q [c_NUM_REGS];
  logic [DATA_W-1:0]     alu_a_q, alu_a_d;
  logic [DATA_W-1:0]     alu_b_q, alu_b_d;
  logic [3:0]            alu_opcode_q, alu_opcode_d;
  logic                  illegal_q, illegal_d;
`ifdef ALU_ZERO_FLAG_EN
  logic                  zero_flag_q, zero_flag_d;
`endif

  // Field extraction from the captured instruction word
  logic [3:0]            w_op;
  logic [REG_ADDR_W-1:0] w_rd;
  logic [REG_ADDR_W-1:0] w_rs1;
  logic [REG_ADDR_W-1:0] w_rs2;
  logic [7:0]            w_imm;
  logic [3:0]            w_onehot;
  logic                  w_is_alu;

  // Register-file write port
  logic                  w_rf_we;
  logic [REG_ADDR_W-1:0] w_rf_waddr;
  logic [DATA_W-1:0]     w_rf_wdata;

  assign w_op  = instr_q[15:12];
  assign w_rd  = REG_ADDR_W'(instr_q[11:10]);
  assign w_rs1 = REG_ADDR_W'(instr_q[9:8]);
  assign w_rs2 = REG_ADDR_W'(instr_q[7:6]);
  assign w_imm = instr_q[7:0];

  // Map the op field onto the ALU one-hot opcode; non-ALU ops map to hold
  always_comb begin
    w_onehot = c_ALU_HOLD;
    w_is_alu = 1'b0;
    case (w_op)
      c_OP_ADD: begin w_onehot = c_ALU_ADD; w_is_alu = 1'b1; end
      c_OP_OR:  begin w_onehot = c_ALU_OR;  w_is_alu = 1'b1; end
      c_OP_AND: begin w_onehot = c_ALU_AND; w_is_alu = 1'b1; end
      c_OP_XOR: begin w_onehot = c_ALU_XOR; w_is_alu = 1'b1; end
      default:  begin w_onehot = c_ALU_HOLD; w_is_alu = 1'b0; end
    endcase
  end

  // Next-state, operand/opcode staging and register-file write selection
  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_opcode_d = alu_opcode_q;
    illegal_d    = illegal_q;
    w_rf_we      = 1'b0;
    w_rf_waddr   = w_rd;
    w_rf_wdata   = alu_out;
`ifdef ALU_ZERO_FLAG_EN
    zero_flag_d  = zero_flag_q;
`endif
    case (state_q)
      c_IDLE: begin
        if (instr_valid) begin
          state_d = c_DECODE;
        end
      end
      c_DECODE: begin
        if (w_is_alu) begin
          // Operands are read here, so rd == rs1/rs2 sees the old value
          alu_a_d      = regfile_q[w_rs1];
          alu_b_d      = regfile_q[w_rs2];
          alu_opcode_d = w_onehot;
          state_d      = c_EXEC;
        end else if (w_op == c_OP_LDI) begin
          w_rf_we    = 1'b1;
          w_rf_wdata = DATA_W'(w_imm);
`ifdef ALU_ZERO_FLAG_EN
          zero_flag_d = (w_imm == 8'h00);
`endif
          state_d    = c_IDLE;
        end else if (w_op == c_OP_NOP) begin
          state_d = c_IDLE;
        end else begin
          illegal_d = 1'b1;
          state_d   = c_IDLE;
        end
      end
      c_EXEC: begin
        // ALU samples operands at the end of this cycle; drop to hold after
        alu_opcode_d = c_ALU_HOLD;
        state_d      = c_WB;
      end
      c_WB: begin
        w_rf_we    = 1'b1;
        w_rf_wdata = alu_out;
`ifdef ALU_ZERO_FLAG_EN
        zero_flag_d = (alu_out == '0);
`endif
        state_d    = c_IDLE;
      end
      default: begin
        state_d = c_IDLE;
      end
    endcase
  end

  // Control and operand registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= c_IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_opcode_q <= c_ALU_HOLD;
      illegal_q    <= 1'b0;
`ifdef ALU_ZERO_FLAG_EN
      zero_flag_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_opcode_q <= alu_opcode_d;
      illegal_q    <= illegal_d;
`ifdef ALU_ZERO_FLAG_EN
      zero_flag_q  <= zero_flag_d;
`endif
    end
  end

  // Capture the instruction word on the accept edge only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= '0;
    end else if ((state_q == c_IDLE) && instr_valid) begin
      instr_q <= instr;
    end
  end

  // Register file: single write port, cleared on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < c_NUM_REGS; i++) begin
        regfile_q[i] <= '0;
      end
    end else if (w_rf_we) begin
      regfile_q[w_rf_waddr] <= w_rf_wdata;
    end
  end

  assign instr_ready = (state_q == c_IDLE);
  assign busy        = (state_q != c_IDLE);
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_opcode  = alu_opcode_q;
  assign illegal     = illegal_q;
  assign dbg_data    = regfile_q[dbg_addr];
`ifdef ALU_ZERO_FLAG_EN
  assign zero_flag   = zero_flag_q;
`endif

endmodule
`default_nettype wire
